// File: rtl/mac_learn_table.sv
// MAC learning table: parallel-compare lookup, three-state learn engine
// with match / free / least-hit replacement, saturating hit counters,
// periodic aging and whole-table flush.
module mac_learn_table #(
  parameter int NUM_ENTRIES = 16,
  parameter int MAX_HIT     = 16,
  parameter int NUM_PORTS   = 4,
  parameter int AGE_PERIOD  = 1024,
  localparam int HW = $clog2(MAX_HIT),
  localparam int PW = $clog2(NUM_PORTS),
  localparam int IW = $clog2(NUM_ENTRIES),
  localparam int OW = IW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lkp_valid,
  output logic          lkp_ready,
  input  logic [47:0]   lkp_mac,
  output logic          rsp_valid,
  output logic          rsp_hit,
  output logic [PW-1:0] rsp_port,
  input  logic          lrn_valid,
  output logic          lrn_ready,
  input  logic [47:0]   lrn_mac,
  input  logic [PW-1:0] lrn_port,
  output logic          lrn_done,
  input  logic          flush,
  output logic [OW-1:0] occupancy
);

  localparam int AW = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;
  localparam logic [HW-1:0] HIT_MAX  = HW'(MAX_HIT - 1);
  localparam logic [AW-1:0] AGE_LAST = AW'(AGE_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, WRITE} state_t;
  state_t state_q, state_d;

  // Flattened views of the per-entry registers held in g_entry.
  logic          ent_valid [NUM_ENTRIES];
  logic [47:0]   ent_mac   [NUM_ENTRIES];
  logic [PW-1:0] ent_port  [NUM_ENTRIES];
  logic [HW-1:0] ent_hit   [NUM_ENTRIES];

  logic [AW-1:0] age_q;
  logic          tick;
  logic          lkp_fire, lrn_fire, wr_en;
  logic          lkp_hit;
  logic [IW-1:0] lkp_idx;
  logic [47:0]   lrn_mac_q;
  logic [PW-1:0] lrn_port_q;
  logic [IW-1:0] tgt_q, tgt_d;
  logic          rsp_valid_q, rsp_hit_q;
  logic [PW-1:0] rsp_port_q;
  logic [OW-1:0] occ_sum;

  assign tick      = (age_q == AGE_LAST);
  assign lkp_ready = ~tick;
  assign lkp_fire  = lkp_valid & lkp_ready;
  assign lrn_fire  = lrn_valid & lrn_ready;

  // Free-running age counter; its last value is the aging tick cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) age_q <= '0;
    else if (tick)       age_q <= '0;
    else                 age_q <= age_q + 1'b1;
  end

  // Lookup compare against registered table state; lowest matching index wins.
  always_comb begin
    lkp_hit = 1'b0;
    lkp_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (ent_valid[i] && ent_mac[i] == lkp_mac) begin
        lkp_hit = 1'b1;
        lkp_idx = IW'(i);
      end
    end
  end

  // Lookup response register, one cycle after acceptance; port is 0 on miss.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_port_q  <= '0;
    end else begin
      rsp_valid_q <= lkp_fire;
      rsp_hit_q   <= lkp_fire & lkp_hit;
      rsp_port_q  <= (lkp_fire && lkp_hit) ? ent_port[lkp_idx] : '0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_port  = rsp_port_q;

  // Learn target: existing match, else lowest free slot, else least-hit (highest index on ties).
  always_comb begin
    logic          m_found, f_found;
    logic [IW-1:0] m_idx, f_idx, min_idx;
    logic [HW-1:0] min_cnt;
    m_found = 1'b0;
    f_found = 1'b0;
    m_idx   = '0;
    f_idx   = '0;
    min_idx = '0;
    min_cnt = '1;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (ent_valid[i] && ent_mac[i] == lrn_mac_q) begin
        m_found = 1'b1;
        m_idx   = IW'(i);
      end
      if (!ent_valid[i]) begin
        f_found = 1'b1;
        f_idx   = IW'(i);
      end
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (ent_hit[i] <= min_cnt) begin
        min_cnt = ent_hit[i];
        min_idx = IW'(i);
      end
    end
    tgt_d = m_found ? m_idx : (f_found ? f_idx : min_idx);
  end

  // Learn FSM state register; flush or reset abandons any learn in flight.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) state_q <= IDLE;
    else                 state_q <= state_d;
  end

  // Learn FSM next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    lrn_ready = 1'b0;
    lrn_done  = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      IDLE: begin
        lrn_ready = ~tick;
        if (lrn_valid && !tick) state_d = SEARCH;
      end
      SEARCH: state_d = WRITE;
      WRITE: begin
        lrn_done = 1'b1;
        wr_en    = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the learn request on acceptance and the chosen target in SEARCH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lrn_mac_q  <= '0;
      lrn_port_q <= '0;
      tgt_q      <= '0;
    end else begin
      if (lrn_fire)            lrn_mac_q  <= lrn_mac;
      if (lrn_fire)            lrn_port_q <= lrn_port;
      if (state_q == SEARCH)   tgt_q      <= tgt_d;
    end
  end

  for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
    logic          valid_q;
    logic [47:0]   mac_q;
    logic [PW-1:0] port_q;
    logic [HW-1:0] hit_q;
    logic          wr_sel, hit_sel;

    assign wr_sel  = wr_en && (tgt_q == IW'(gi));
    assign hit_sel = lkp_fire && lkp_hit && (lkp_idx == IW'(gi));

    // Entry status: flush/reset, then learn write, then aging, then lookup hit.
    always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
        valid_q <= 1'b0;
        hit_q   <= '0;
      end else if (wr_sel) begin
        valid_q <= 1'b1;
        hit_q   <= HW'(1);
      end else if (tick && valid_q) begin
        if (hit_q == '0) valid_q <= 1'b0;
        else             hit_q   <= hit_q - 1'b1;
      end else if (hit_sel && hit_q != HIT_MAX) begin
        hit_q <= hit_q + 1'b1;
      end
    end

    // MAC and port only matter while valid, so they change on learn writes only.
    always_ff @(posedge clk) begin
      if (rst_n && !flush && wr_sel) begin
        mac_q  <= lrn_mac_q;
        port_q <= lrn_port_q;
      end
    end

    assign ent_valid[gi] = valid_q;
    assign ent_mac[gi]   = mac_q;
    assign ent_port[gi]  = port_q;
    assign ent_hit[gi]   = hit_q;
  end

  // Occupancy is the population count of the registered valid bits.
  always_comb begin
    occ_sum = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) occ_sum = occ_sum + OW'(ent_valid[i]);
  end

  assign occupancy = occ_sum;

endmodule
